// File: rtl/strip_allocator_pkg.sv
// Shared board geometry, FSM states and strip tables for the strip allocator.
package strip_allocator_pkg;

   localparam int BOARD_W    = 32;
   localparam int NUM_STRIPS = 13;
   localparam int UW         = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK1,
      S_CHK2,
      S_CHK3,
      S_RESP
   } state_t;

   typedef logic [NUM_STRIPS:1][UW-1:0] used_vec_t;

   function automatic logic [6:0] strip_y(input logic [3:0] id);
      logic [6:0] y;
      case (id)
         4'd1:    y = 7'd0;
         4'd2:    y = 7'd8;
         4'd3:    y = 7'd16;
         4'd4:    y = 7'd25;
         4'd5:    y = 7'd32;
         4'd6:    y = 7'd42;
         4'd7:    y = 7'd48;
         4'd8:    y = 7'd59;
         4'd9:    y = 7'd64;
         4'd10:   y = 7'd76;
         4'd11:   y = 7'd80;
         4'd12:   y = 7'd96;
         4'd13:   y = 7'd112;
         default: y = 7'd0;
      endcase
      return y;
   endfunction

   function automatic logic [4:0] strip_h(input logic [3:0] id);
      logic [4:0] h;
      case (id)
         4'd1:    h = 5'd8;
         4'd2:    h = 5'd8;
         4'd3:    h = 5'd9;
         4'd4:    h = 5'd7;
         4'd5:    h = 5'd10;
         4'd6:    h = 5'd6;
         4'd7:    h = 5'd11;
         4'd8:    h = 5'd5;
         4'd9:    h = 5'd12;
         4'd10:   h = 5'd4;
         4'd11:   h = 5'd16;
         4'd12:   h = 5'd16;
         4'd13:   h = 5'd16;
         default: h = 5'd0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/strip_fit_check.sv
// Combinational first-fit test of one candidate strip against its used count.
module strip_fit_check
   import strip_allocator_pkg::*;
(
   input  logic [3:0]    id_i,
   input  logic [UW-1:0] width_i,
   input  used_vec_t     used_i,
   output logic          valid_id_o,
   output logic          fits_o,
   output logic [UW-1:0] x_o
);

   logic [UW-1:0] sel;
   logic [UW:0]   end_col;

   always_comb begin
      sel = '0;
      for (int i = 1; i <= NUM_STRIPS; i++) begin
         if (id_i == 4'(i)) sel = used_i[i];
      end
   end

   // One extra bit so a nearly full strip cannot wrap into a false fit
   assign end_col    = {1'b0, sel} + {1'b0, width_i};
   assign valid_id_o = (id_i != 4'd0) && (id_i <= 4'(NUM_STRIPS));
   assign fits_o     = valid_id_o && (end_col <= 7'(BOARD_W));
   assign x_o        = sel;

endmodule

// File: rtl/strip_allocator.sv
// Tracks per-strip column usage and first-fit places a program into one of
// three candidate strips, one candidate per cycle.
module strip_allocator
   import strip_allocator_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] height_in,
   input  logic [4:0] width_in,
   input  logic [3:0] str_id_1,
   input  logic [3:0] str_id_2,
   input  logic [3:0] str_id_3,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_ok,
   output logic [3:0] out_strip,
   output logic [5:0] out_x,
   output logic [6:0] out_y
);

   state_t        state_q, state_d;
   used_vec_t     used_q, used_d;
   logic [4:0]    width_q, width_d;
   logic [3:0]    id1_q, id1_d;
   logic [3:0]    id2_q, id2_d;
   logic [3:0]    id3_q, id3_d;
   logic          ok_q, ok_d;
   logic [3:0]    strip_q, strip_d;
   logic [5:0]    x_q, x_d;
   logic [6:0]    y_q, y_d;
   logic          vld_q, vld_d;

   logic [3:0]    cur_id;
   logic          cur_valid;
   logic          cur_fits;
   logic [UW-1:0] cur_x;
   logic          unused_height;

   assign unused_height = ^height_in;

   always_comb begin
      case (state_q)
         S_CHK1:  cur_id = id1_q;
         S_CHK2:  cur_id = id2_q;
         S_CHK3:  cur_id = id3_q;
         default: cur_id = 4'd0;
      endcase
   end

   strip_fit_check u_fit (
      .id_i       (cur_id),
      .width_i    ({1'b0, width_q}),
      .used_i     (used_q),
      .valid_id_o (cur_valid),
      .fits_o     (cur_fits),
      .x_o        (cur_x)
   );

   always_comb begin
      state_d = state_q;
      used_d  = used_q;
      width_d = width_q;
      id1_d   = id1_q;
      id2_d   = id2_q;
      id3_d   = id3_q;
      ok_d    = ok_q;
      strip_d = strip_q;
      x_d     = x_q;
      y_d     = y_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               width_d = width_in;
               id1_d   = str_id_1;
               id2_d   = str_id_2;
               id3_d   = str_id_3;
               ok_d    = 1'b0;
               strip_d = 4'd0;
               x_d     = 6'd0;
               y_d     = 7'd0;
               if (width_in == 5'd0 ||
                   {1'b0, width_in} > 6'(BOARD_W))
                  state_d = S_RESP;
               else
                  state_d = S_CHK1;
            end
         end
         S_CHK1, S_CHK2, S_CHK3: begin
            if (cur_fits) begin
               ok_d    = 1'b1;
               strip_d = cur_id;
               x_d     = cur_x;
               y_d     = strip_y(cur_id);
               for (int i = 1; i <= NUM_STRIPS; i++) begin
                  if (cur_id == 4'(i))
                     used_d[i] = used_q[i] + {1'b0, width_q};
               end
               state_d = S_RESP;
            end else begin
               case (state_q)
                  S_CHK1:  state_d = S_CHK2;
                  S_CHK2:  state_d = S_CHK3;
                  default: state_d = S_RESP;
               endcase
            end
         end
         S_RESP: begin
            if (vld_q && out_ready) begin
               state_d = S_IDLE;
               ok_d    = 1'b0;
               strip_d = 4'd0;
               x_d     = 6'd0;
               y_d     = 7'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A board wipe beats any commit happening in the same cycle
      if (clr) begin
         state_d = S_IDLE;
         used_d  = '0;
         ok_d    = 1'b0;
         strip_d = 4'd0;
         x_d     = 6'd0;
         y_d     = 7'd0;
      end
   end

   // Response flag lags RESP entry by one cycle and drops on the handshake
   assign vld_d = !clr && (state_q == S_RESP) && !(vld_q && out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         used_q  <= '0;
         width_q <= 5'd0;
         id1_q   <= 4'd0;
         id2_q   <= 4'd0;
         id3_q   <= 4'd0;
         ok_q    <= 1'b0;
         strip_q <= 4'd0;
         x_q     <= 6'd0;
         y_q     <= 7'd0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         used_q  <= used_d;
         width_q <= width_d;
         id1_q   <= id1_d;
         id2_q   <= id2_d;
         id3_q   <= id3_d;
         ok_q    <= ok_d;
         strip_q <= strip_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vld_q   <= vld_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = vld_q;
   assign out_ok    = ok_q;
   assign out_strip = strip_q;
   assign out_x     = x_q;
   assign out_y     = y_q;

endmodule

// File: tb/tb_strip_allocator.sv
// Bench for strip_allocator: directed scenarios plus random traffic, all
// responses checked against a first-fit board model.
module tb_strip_allocator;

   logic       clk = 1'b0;
   logic       rst, clr, in_valid, out_ready;
   logic       in_ready, out_valid, out_ok;
   logic [4:0] height_in, width_in;
   logic [3:0] str_id_1, str_id_2, str_id_3, out_strip;
   logic [5:0] out_x;
   logic [6:0] out_y;

   strip_allocator dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .height_in (height_in),
      .width_in  (width_in),
      .str_id_1  (str_id_1),
      .str_id_2  (str_id_2),
      .str_id_3  (str_id_3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ok    (out_ok),
      .out_strip (out_strip),
      .out_x     (out_x),
      .out_y     (out_y)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int used_m [14];
   int ytab   [14] = '{0, 0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};

   bit expect_resp = 1'b0;
   int e_ok, e_strip, e_x, e_y, e_lat;
   int g_ok, g_strip, g_x, g_y;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // First-fit over the candidate list using plain per-strip column counts
   task automatic model(input int w, input int a, input int b, input int c);
      int ids [3];
      ids = '{a, b, c};
      e_ok = 0; e_strip = 0; e_x = 0; e_y = 0;
      if (w == 0 || w > 32) begin
         e_lat = 1;
      end else begin
         e_lat = 4;
         for (int k = 0; k < 3; k++) begin
            if (e_ok == 0 && ids[k] >= 1 && ids[k] <= 13 &&
                used_m[ids[k]] + w <= 32) begin
               e_ok    = 1;
               e_strip = ids[k];
               e_x     = used_m[ids[k]];
               e_y     = ytab[ids[k]];
               used_m[ids[k]] += w;
               e_lat   = k + 2;
            end
         end
      end
   endtask

   task automatic model_wipe();
      for (int i = 0; i < 14; i++) used_m[i] = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (!expect_resp) chk("spurious_out_valid", int'(out_valid), 0);
         if (out_valid) begin
            chk("out_ok",    int'(out_ok),    e_ok);
            chk("out_strip", int'(out_strip), e_strip);
            chk("out_x",     int'(out_x),     e_x);
            chk("out_y",     int'(out_y),     e_y);
            chk("in_ready_busy", int'(in_ready), 0);
         end
      end
   end

   task automatic do_req(input int w, input int a, input int b,
                         input int c, input int hold);
      int n;
      @(negedge clk);
      in_valid  = 1'b1;
      width_in  = 5'(w);
      height_in = 5'($urandom);
      str_id_1  = 4'(a);
      str_id_2  = 4'(b);
      str_id_3  = 4'(c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model(w, a, b, c);
      expect_resp = 1'b1;
      n = 0;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, e_lat);
      g_ok    = int'(out_ok);
      g_strip = int'(out_strip);
      g_x     = int'(out_x);
      g_y     = int'(out_y);
      // Competing requests while the response is stalled must be ignored
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b1;
         width_in = 5'd1;
         str_id_1 = 4'd1;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      expect_resp = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic clr_req(input int w, input int a, input int b,
                          input int c, input int cyc);
      @(negedge clk);
      in_valid = 1'b1;
      width_in = 5'(w);
      str_id_1 = 4'(a);
      str_id_2 = 4'(b);
      str_id_3 = 4'(c);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (cyc) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_wipe();
      chk("clr_in_ready",  int'(in_ready),  1);
      chk("clr_out_valid", int'(out_valid), 0);
   endtask

   task automatic idle_clr();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      model_wipe();
   endtask

   task automatic lit(input int ok, input int s, input int x, input int y);
      chk("lit_ok",    g_ok,    ok);
      chk("lit_strip", g_strip, s);
      chk("lit_x",     g_x,     x);
      chk("lit_y",     g_y,     y);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      height_in = '0; width_in = '0;
      str_id_1 = '0; str_id_2 = '0; str_id_3 = '0;
      model_wipe();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  int'(in_ready),  1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_ok",    int'(out_ok),    0);
      chk("rst_out_strip", int'(out_strip), 0);
      chk("rst_out_x",     int'(out_x),     0);
      chk("rst_out_y",     int'(out_y),     0);

      do_req(10, 1, 2, 3, 0);  lit(1, 1, 0, 0);
      do_req(10, 1, 2, 3, 0);  lit(1, 1, 10, 0);
      do_req(10, 1, 2, 3, 0);  lit(1, 1, 20, 0);
      do_req(10, 1, 2, 3, 0);  lit(1, 2, 0, 8);

      do_req(16, 13, 12, 11, 0); lit(1, 13, 0, 112);
      do_req(16, 13, 12, 11, 0); lit(1, 13, 16, 112);
      do_req(16, 13, 12, 11, 0); lit(1, 12, 0, 96);

      do_req(5, 0, 0, 0, 0);   lit(0, 0, 0, 0);
      do_req(0, 1, 2, 3, 0);   lit(0, 0, 0, 0);
      do_req(2, 1, 0, 0, 0);   lit(1, 1, 30, 0);

      do_req(3, 4, 0, 0, 5);   lit(1, 4, 0, 25);

      clr_req(10, 0, 5, 0, 1);
      do_req(10, 1, 0, 0, 0);  lit(1, 1, 0, 0);
      do_req(10, 5, 0, 0, 0);  lit(1, 5, 0, 32);

      do_req(20, 6, 6, 6, 0);  lit(1, 6, 0, 42);
      do_req(20, 6, 6, 7, 0);  lit(1, 7, 0, 48);

      for (int r = 0; r < 300; r++) begin
         if ($urandom_range(0, 29) == 0) begin
            idle_clr();
         end else if ($urandom_range(0, 19) == 0) begin
            clr_req(int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)));
         end else begin
            do_req(($urandom_range(0, 7) == 0) ?
                      int'($urandom_range(0, 31)) :
                      int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
         end
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
